// File: rtl/fxp_block_accumulator_if.sv
// rtl/fxp_block_accumulator_if.sv - sample-in / result-out handshake bundle for fxp_block_accumulator
interface fxp_block_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12
);
    logic              i_clear;
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic              i_sub;
    logic              o_valid;
    logic              o_ready;
    logic [ACC_W-1:0]  o_data;
    logic              o_sat;

    modport master (
        output i_clear, i_valid, i_data, i_sub, o_ready,
        input  i_ready, o_valid, o_data, o_sat
    );

    modport slave (
        input  i_clear, i_valid, i_data, i_sub, o_ready,
        output i_ready, o_valid, o_data, o_sat
    );
endinterface

// File: rtl/fxp_block_accumulator.sv
// rtl/fxp_block_accumulator.sv - signed saturating add/subtract accumulator emitting one result per BLOCK_LEN samples
module fxp_block_accumulator #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 12,
    parameter int BLOCK_LEN = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    fxp_block_accumulator_if.slave   bus
);
    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {ST_ACCUM, ST_OUTPUT} state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic                     sat_flag;
    logic                     o_valid_q;
    logic [ACC_W-1:0]         o_data_q;
    logic                     o_sat_q;

    logic signed [ACC_W:0]    ext_acc;
    logic signed [ACC_W:0]    ext_smp;
    logic signed [ACC_W:0]    sum;
    logic                     ovf;
    logic signed [ACC_W-1:0]  acc_nxt;

    // One guard bit makes acc - (-2^(DATA_W-1)) exact before clamping.
    always_comb begin
        ext_acc = {acc[ACC_W-1], acc};
        ext_smp = {{(ACC_W+1-DATA_W){bus.i_data[DATA_W-1]}}, bus.i_data};
        sum     = bus.i_sub ? (ext_acc - ext_smp) : (ext_acc + ext_smp);
        ovf     = (sum[ACC_W] != sum[ACC_W-1]);
        acc_nxt = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_sat_q   <= 1'b0;
        end else if (bus.i_clear) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_sat_q   <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (bus.i_valid) begin
                        acc      <= acc_nxt;
                        sat_flag <= sat_flag | ovf;
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            state     <= ST_OUTPUT;
                            o_valid_q <= 1'b1;
                            o_data_q  <= acc_nxt;
                            o_sat_q   <= sat_flag | ovf;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_OUTPUT: begin
                    // Result registers hold until taken; samples are ignored here.
                    if (bus.o_ready) begin
                        state     <= ST_ACCUM;
                        acc       <= '0;
                        cnt       <= '0;
                        sat_flag  <= 1'b0;
                        o_valid_q <= 1'b0;
                        o_data_q  <= '0;
                        o_sat_q   <= 1'b0;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    assign bus.i_ready = (state == ST_ACCUM);
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_sat   = o_sat_q;
endmodule
